mx_int_block_quantizer: RTL and testbench

- Streaming encoder that turns wide signed fixed-point activations into MX integer blocks.
- Each block has k signed elements of bit_width bits plus one 8-bit shared scale.
- Producer-side counterpart of the block dot-product datapath: its o_X/o_S drive a k-element slice of i_X/i_S there.
- Collects one block over k/P input beats, finds the block's maximum magnitude, and emits the quantized block in parallel under valid/ready.

---
 rtl/mx_pkg.sv | 21 ++
 rtl/lead_one_pos.sv | 19 +
 rtl/mx_int_block_quantizer.sv | 130 +++++++++++++
 tb/tb_mx_int_block_quantizer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mx_pkg.sv
// Shared types and helpers for the MX integer block quantizer.
package mx_pkg;

  localparam int SCALE_W   = 8;
  localparam int SCALE_MAX = 255;

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Scale plus shift, saturated to the 8-bit scale range.
  function automatic logic [SCALE_W-1:0] sat_add_scale(input logic [SCALE_W-1:0] scale,
                                                       input logic [SCALE_W-1:0] sh);
    logic [SCALE_W:0] sum;
    sum = {1'b0, scale} + {1'b0, sh};
    if (sum[SCALE_W]) return SCALE_W'(SCALE_MAX);
    return sum[SCALE_W-1:0];
  endfunction

endpackage

// File: rtl/lead_one_pos.sv
// Combinational leading-one index of an unsigned vector, with an all-zero flag.
module lead_one_pos #(
  parameter int w = 24,
  localparam int PW = (w > 1) ? $clog2(w) : 1
) (
  input  logic [w-1:0]  vec,
  output logic [PW-1:0] pos,
  output logic          zero
);

  always_comb begin
    pos  = '0;
    zero = (vec == '0);
    for (int i = 0; i < w; i++) begin
      if (vec[i]) pos = PW'(i);
    end
  end

endmodule

// File: rtl/mx_int_block_quantizer.sv
// Collects k signed elements over k/P beats and emits them as one MX integer
// block (k narrow elements plus a shared 8-bit scale) under valid/ready.
module mx_int_block_quantizer
  import mx_pkg::*;
#(
  parameter int k         = 32,
  parameter int P         = 8,
  parameter int in_width  = 24,
  parameter int bit_width = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic signed [in_width-1:0]  i_data [P],
  input  logic [SCALE_W-1:0]          i_scale,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic signed [bit_width-1:0] o_X [k],
  output logic [SCALE_W-1:0]          o_S
);

  localparam int NB    = k / P;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int POS_W = (in_width > 1) ? $clog2(in_width) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NB - 1);
  localparam logic signed [in_width-1:0] Q_MAX = in_width'((2 ** (bit_width - 1)) - 1);
  localparam logic signed [in_width-1:0] Q_MIN = -Q_MAX;

  // Symmetric clamp keeps the most negative code unused.
  function automatic logic signed [bit_width-1:0] clamp_elem(input logic signed [in_width-1:0] v);
    if (v > Q_MAX) return Q_MAX[bit_width-1:0];
    if (v < Q_MIN) return Q_MIN[bit_width-1:0];
    return v[bit_width-1:0];
  endfunction

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q;
  logic [in_width-1:0]         acc_q;
  logic [SCALE_W-1:0]          scale_q;
  logic signed [in_width-1:0]  buffer_q [k];

  logic                        accept;
  logic [in_width-1:0]         lane_abs;
  logic [in_width-1:0]         beat_or;
  logic [POS_W-1:0]            lead_pos;
  logic                        acc_zero;
  logic [SCALE_W-1:0]          sh;
  logic signed [in_width-1:0]  shifted;

  assign accept = i_valid && (state_q == FILL);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= FILL;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    o_ready = 1'b0;
    o_valid = 1'b0;
    case (state_q)
      FILL: begin
        o_ready = 1'b1;
        if (i_valid && (cnt_q == LAST_BEAT)) state_d = EMIT;
      end
      EMIT: begin
        o_valid = 1'b1;
        if (i_ready) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // Magnitude of -2^(in_width-1) wraps to exactly 2^(in_width-1) as unsigned.
  always_comb begin
    lane_abs = '0;
    beat_or  = '0;
    for (int j = 0; j < P; j++) begin
      lane_abs = i_data[j][in_width-1] ? $unsigned(-i_data[j]) : $unsigned(i_data[j]);
      beat_or  = beat_or | lane_abs;
    end
  end

  // Stage: beat capture into the block buffer and magnitude accumulator
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      scale_q <= '0;
      for (int i = 0; i < k; i++) buffer_q[i] <= '0;
    end else if (accept) begin
      cnt_q <= (cnt_q == LAST_BEAT) ? '0 : cnt_q + 1'b1;
      if (cnt_q == '0) begin
        acc_q   <= beat_or;
        scale_q <= i_scale;
      end else begin
        acc_q <= acc_q | beat_or;
      end
      for (int b = 0; b < NB; b++) begin
        if (cnt_q == CNT_W'(b)) begin
          for (int j = 0; j < P; j++) buffer_q[b*P + j] <= i_data[j];
        end
      end
    end
  end

  lead_one_pos #(.w(in_width)) u_lead_one (
    .vec  (acc_q),
    .pos  (lead_pos),
    .zero (acc_zero)
  );

  // Stage: quantization, purely from registered block state
  always_comb begin
    sh = '0;
    if (!acc_zero && (int'(lead_pos) + 2 > bit_width))
      sh = SCALE_W'(int'(lead_pos) + 2 - bit_width);
  end

  always_comb begin
    shifted = '0;
    for (int i = 0; i < k; i++) begin
      shifted = buffer_q[i] >>> sh;
      o_X[i]  = clamp_elem(shifted);
    end
    o_S = sat_add_scale(scale_q, sh);
  end

endmodule

// File: tb/tb_mx_int_block_quantizer.sv
// Directed bench for mx_int_block_quantizer with an arithmetic reference model.
module tb_mx_int_block_quantizer;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_valid = 1'b0;
  logic              o_ready;
  logic signed [23:0] i_data [8];
  logic [7:0]        i_scale = '0;
  logic              o_valid;
  logic              i_ready = 1'b0;
  logic signed [7:0] o_X [32];
  logic [7:0]        o_S;

  int n_cmp = 0;
  int n_err = 0;
  int blk [32];
  int exp_x [32];
  int exp_s = 0;
  bit exp_have = 1'b0;
  bit run_cmp = 1'b0;

  mx_int_block_quantizer #(.k(32), .P(8), .in_width(24), .bit_width(8)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .i_scale (i_scale),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_X     (o_X),
    .o_S     (o_S)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference: shift so the largest magnitude fits bit_width-1 magnitude bits.
  task automatic model(input int sc);
    int maxabs, m, sh, v;
    maxabs = 0;
    for (int i = 0; i < 32; i++) begin
      v = (blk[i] < 0) ? -blk[i] : blk[i];
      if (v > maxabs) maxabs = v;
    end
    m = 0;
    while ((maxabs >> (m + 1)) != 0) m++;
    sh = (m + 1 - 7 > 0) ? (m + 1 - 7) : 0;
    for (int i = 0; i < 32; i++) begin
      v = blk[i] >>> sh;
      if (v > 127) v = 127;
      if (v < -127) v = -127;
      exp_x[i] = v;
    end
    exp_s = (sc + sh > 255) ? 255 : sc + sh;
  endtask

  task automatic send_block(input int nbeats, input int sc, input int gap);
    int t;
    for (int b = 0; b < nbeats; b++) begin
      repeat (gap) begin
        @(posedge i_clk); #1;
      end
      t = 0;
      while (!o_ready && t < 20) begin
        @(posedge i_clk); #1;
        t++;
      end
      if (t == 20) check("ready_timeout", 0, 1);
      i_valid = 1'b1;
      i_scale = (b == 0) ? sc[7:0] : 8'h55;
      for (int j = 0; j < 8; j++) i_data[j] = blk[b*8 + j][23:0];
      @(posedge i_clk); #1;
      i_valid = 1'b0;
    end
    if (nbeats == 4) begin
      model(sc);
      exp_have = 1'b1;
      check("valid_latency", int'(o_valid), 1);
    end
  endtask

  task automatic drain(input int hold);
    int t;
    t = 0;
    while (!o_valid && t < 20) begin
      @(posedge i_clk); #1;
      t++;
    end
    if (t == 20) check("valid_timeout", 0, 1);
    repeat (hold) begin
      @(posedge i_clk); #1;
    end
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    exp_have = 1'b0;
    check("post_hs_valid", int'(o_valid), 0);
    check("post_hs_ready", int'(o_ready), 1);
  endtask

  // Per-cycle comparison of the DUT against the model.
  always @(negedge i_clk) begin
    if (run_cmp) begin
      check("ready_vs_valid", int'(o_ready), int'(!o_valid));
      if (o_valid) begin
        int bad;
        bad = -1;
        if (!exp_have) check("unexpected_valid", 1, 0);
        else begin
          for (int i = 0; i < 32; i++) if (bad < 0 && int'(o_X[i]) != exp_x[i]) bad = i;
          if (bad >= 0) check($sformatf("o_X[%0d]", bad), int'(o_X[bad]), exp_x[bad]);
          else check("o_X_block", 0, 0 + ((bad >= 0) ? 1 : 0));
          check("o_S", int'(o_S), exp_s);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int j = 0; j < 8; j++) i_data[j] = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_valid", int'(o_valid), 0);
    check("rst_ready", int'(o_ready), 1);
    check("rst_S", int'(o_S), 0);
    check("rst_X0", int'(o_X[0]), 0);
    check("rst_X31", int'(o_X[31]), 0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    run_cmp = 1'b1;

    // All 100, no shift
    for (int i = 0; i < 32; i++) blk[i] = 100;
    send_block(4, 127, 0);
    check("t1_X7", int'(o_X[7]), 100);
    check("t1_S", int'(o_S), 127);
    drain(0);

    // Shift of 3 with floor on negatives
    for (int i = 0; i < 32; i++) blk[i] = 100;
    blk[0] = 1000;
    blk[5] = -100;
    send_block(4, 127, 0);
    check("model_t2_X0", exp_x[0], 125);
    check("model_t2_X5", exp_x[5], -13);
    check("t2_X0", int'(o_X[0]), 125);
    check("t2_X1", int'(o_X[1]), 12);
    check("t2_X5", int'(o_X[5]), -13);
    check("t2_S", int'(o_S), 130);
    drain(5);

    // Same block with gaps between beats
    send_block(4, 127, 2);
    check("t2g_X0", int'(o_X[0]), 125);
    check("t2g_X5", int'(o_X[5]), -13);
    check("t2g_S", int'(o_S), 130);
    drain(1);

    // Symmetric clamp
    for (int i = 0; i < 32; i++) blk[i] = 0;
    blk[20] = -1023;
    send_block(4, 50, 0);
    check("t3_X20", int'(o_X[20]), -127);
    check("t3_X0", int'(o_X[0]), 0);
    check("t3_S", int'(o_S), 53);
    drain(0);

    // Most negative input, scale saturation
    for (int i = 0; i < 32; i++) blk[i] = 0;
    blk[31] = -8388608;
    send_block(4, 250, 0);
    check("model_t4_S", exp_s, 255);
    check("t4_X31", int'(o_X[31]), -64);
    check("t4_S", int'(o_S), 255);
    drain(2);

    // Reset mid-block, then an all-zero block
    for (int i = 0; i < 32; i++) blk[i] = 77;
    send_block(2, 200, 0);
    #2 i_rst = 1'b1;
    #1;
    check("mid_rst_valid", int'(o_valid), 0);
    check("mid_rst_ready", int'(o_ready), 1);
    check("mid_rst_X0", int'(o_X[0]), 0);
    check("mid_rst_S", int'(o_S), 0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    for (int i = 0; i < 32; i++) blk[i] = 0;
    send_block(4, 9, 0);
    check("t5_X0", int'(o_X[0]), 0);
    check("t5_X16", int'(o_X[16]), 0);
    check("t5_S", int'(o_S), 9);
    drain(0);

    repeat (3) @(posedge i_clk);
    #1;
    run_cmp = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
